// File: rtl/vending_key_conditioner.sv
// Turns three raw bouncing active-low keys into clean, one-hot request pulses for
// the vending FSM: per-key sync + debounce, then a priority arbiter with pending slots.

module vkc_key_debounce #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(999_999)
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key_n,
    output logic o_ev
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1  <= 1'b1;
            r_s2  <= 1'b1;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_key_n;
            r_s2 <= r_s1;
            if (r_s2)
                r_cnt <= '0;
            else if (r_cnt < CNT_MAX)
                r_cnt <= r_cnt + ONE;
        end
    end

    // Fires on the single cycle the low run reaches CNT_MAX; saturation keeps it from repeating.
    assign o_ev = !r_s2 && (r_cnt == CNT_MAX - ONE);
endmodule

module vending_key_conditioner #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(999_999)
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_one,
    input  logic key_half,
    input  logic key_refund,
    output logic po_money_one,
    output logic po_money_half,
    output logic po_refund
);
    localparam int NUM_KEYS = 3;

    // Bit order is also priority order: [2]=refund, [1]=one yuan, [0]=half yuan.
    logic [NUM_KEYS-1:0] w_key_n;
    logic [NUM_KEYS-1:0] w_ev;
    logic [NUM_KEYS-1:0] w_req;
    logic [NUM_KEYS-1:0] w_grant;
    logic [NUM_KEYS-1:0] r_pend;
    logic [NUM_KEYS-1:0] r_out;

    assign w_key_n = {key_refund, key_one, key_half};

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
            vkc_key_debounce #(
                .CNT_W   (CNT_W),
                .CNT_MAX (CNT_MAX)
            ) u_deb (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .i_key_n   (w_key_n[g]),
                .o_ev      (w_ev[g])
            );
        end
    endgenerate

    assign w_req = r_pend | w_ev;

    always_comb begin
        w_grant = '0;
        if (w_req[2])
            w_grant[2] = 1'b1;
        else if (w_req[1])
            w_grant[1] = 1'b1;
        else if (w_req[0])
            w_grant[0] = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pend <= '0;
            r_out  <= '0;
        end else begin
            r_pend <= w_req & ~w_grant;
            r_out  <= w_grant;
        end
    end

    assign po_refund     = r_out[2];
    assign po_money_one  = r_out[1];
    assign po_money_half = r_out[0];
endmodule

// File: tb/tb_vending_key_conditioner.sv
// Directed + random bench for vending_key_conditioner, checked every cycle against a
// run-length model of the raw key samples and a priority queue of pending requests.

module tb_vending_key_conditioner;
    localparam int          CNT_W   = 3;
    localparam int          CNT_MAX = 4;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_one = 1'b1;
    logic key_half = 1'b1;
    logic key_refund = 1'b1;
    logic po_money_one;
    logic po_money_half;
    logic po_refund;

    int checks = 0;
    int errors = 0;

    // Model: low-run length of raw samples per key, pending flags, registered outputs.
    int         run [3];
    logic [2:0] m_ev;
    logic [2:0] m_pend;
    logic [2:0] m_out;
    int         npulse [3];

    vending_key_conditioner #(
        .CNT_W   (CNT_W),
        .CNT_MAX (3'(CNT_MAX))
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .key_one       (key_one),
        .key_half      (key_half),
        .key_refund    (key_refund),
        .po_money_one  (po_money_one),
        .po_money_half (po_money_half),
        .po_refund     (po_refund)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        checks++;
        assert ($countones({po_refund, po_money_one, po_money_half}) <= 1)
        else begin
            errors++;
            $error("FAIL onehot obs=%b exp=at most one bit set",
                   {po_refund, po_money_one, po_money_half});
        end
    end

    function automatic logic [2:0] obs_out();
        return {po_refund, po_money_one, po_money_half};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) run[i] = 0;
        m_ev   = '0;
        m_pend = '0;
        m_out  = '0;
    endtask

    task automatic clr_pulses();
        for (int i = 0; i < 3; i++) npulse[i] = 0;
    endtask

    // A press event is the cycle in which the synchronised key has been low for exactly
    // CNT_MAX consecutive samples; the synchroniser delays the raw samples by one edge.
    task automatic model_step(input logic [2:0] raw);
        logic [2:0] req;
        req   = m_pend | m_ev;
        m_out = '0;
        for (int i = 2; i >= 0; i--)
            if (req[i] && m_out == 3'b000) m_out[i] = 1'b1;
        m_pend = req & ~m_out;
        for (int i = 0; i < 3; i++) begin
            m_ev[i] = (run[i] == CNT_MAX);
            if (raw[i])               run[i] = 0;
            else if (run[i] <= CNT_MAX) run[i] = run[i] + 1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Drive raw keys {refund, one, half}, clock once, compare outputs with the model.
    task automatic tick(input logic [2:0] keys);
        logic [2:0] o;
        {key_refund, key_one, key_half} = keys;
        @(posedge sys_clk);
        #1;
        model_step(keys);
        o = obs_out();
        for (int i = 0; i < 3; i++) npulse[i] += int'(o[i]);
        checks++;
        assert (o === m_out)
        else begin
            errors++;
            $error("FAIL outputs obs=%b exp=%b t=%0t", o, m_out, $time);
        end
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input int hold_cycles);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("reset_clear", int'(obs_out()), 0);
        model_reset();
        repeat (hold_cycles) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] k;
        int         n;
        model_reset();
        clr_pulses();

        // Reset and idle
        #3;
        chk("reset_outputs", int'(obs_out()), 0);
        repeat (2) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick(3'b111);
        chk("idle_pulses", npulse[0] + npulse[1] + npulse[2], 0);

        // key_half held low: one pulse only
        clr_pulses();
        for (int i = 0; i < 12; i++) tick(3'b110);
        for (int i = 0; i < 3; i++) tick(3'b111);
        chk("half_hold_pulses", npulse[0], 1);

        // key_one bounce then steady low
        clr_pulses();
        begin
            logic [6:0] pat;
            pat = 7'b0010010;
            for (int i = 6; i >= 0; i--) tick({1'b1, pat[i], 1'b1});
        end
        for (int i = 0; i < 9; i++) tick(3'b101);
        for (int i = 0; i < 3; i++) tick(3'b111);
        chk("one_bounce_pulses", npulse[1], 1);

        // All keys fall together: refund, one, half on consecutive cycles
        clr_pulses();
        for (int i = 0; i < 10; i++) tick(3'b000);
        for (int i = 0; i < 3; i++) tick(3'b111);
        chk("all_refund", npulse[2], 1);
        chk("all_one", npulse[1], 1);
        chk("all_half", npulse[0], 1);

        // Reset while a pulse is high
        n = 0;
        while (po_money_one !== 1'b1 && n < 12) begin
            tick(3'b101);
            n++;
        end
        chk("pulse_before_reset", int'(po_money_one), 1);
        async_reset(2);
        for (int i = 0; i < 3; i++) tick(3'b111);

        // key_one held low, reset mid-debounce, key kept low through release
        clr_pulses();
        for (int i = 0; i < 4; i++) tick(3'b101);
        key_one = 1'b0;
        async_reset(3);
        for (int i = 0; i < 12; i++) tick(3'b101);
        for (int i = 0; i < 3; i++) tick(3'b111);
        chk("reset_held_pulses", npulse[1], 1);

        // 10 presses on key_half
        clr_pulses();
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 6; i++) tick(3'b110);
            for (int i = 0; i < 3; i++) tick(3'b111);
        end
        for (int i = 0; i < 4; i++) tick(3'b111);
        chk("half_10_presses", npulse[0], 10);

        // Random bouncing on all keys: each key toggles rarely so real presses occur
        k = 3'b111;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) k[b] = ~k[b];
            tick(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
